spi_slave_port: RTL
===================

Name: spi_slave_port

Overview:
SPI responder (slave) shift engine, the peripheral-side counterpart of the team's SPI master word path. Oversamples SCLK/CS_n/MOSI in the system clock domain, assembles WordLen-bit words from MOSI, and drives MISO from a one-entry transmit buffer. Used in loopback/test harnesses and as an on-chip peripheral port facing the SPI master.

Parameters:
WordLen, 8, bits per word (2..32), MSB first.
CPOL, 0, SCLK idle level.
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
clk  in  1  system clock; f_clk >= 8 x f_SCLK.
rst  in  1  asynchronous, active-high reset.
Sclk  in  1  SPI clock from master (asynchronous).
CsN  in  1  chip select, active low (asynchronous).
Mosi  in  1  serial data from master (asynchronous).
Miso  out  1  serial data to master.
MisoOe  out  1  MISO output enable (1 only while selected).
TxData  in  WordLen  next word to transmit.
TxValid  in  1  TxData valid.
TxReady  out  1  transmit buffer empty; transfer on TxValid&TxReady.
RxData  out  WordLen  last received word, held until the next word.
RxValid  out  1  one-clk pulse: RxData updated.
TxUnderrun  out  1  one-clk pulse: word load found the buffer empty.
FrameErr  out  1  one-clk pulse: CsN rose mid-word.
Busy  out  1  high in ACTIVE.

Behaviour:
- Reset (async): all outputs 0 except TxReady=1; FSM=IDLE; counters, shift registers, and buffer cleared.
- Sclk, CsN, Mosi each pass a 2-FF synchronizer. A third SCLK stage feeds edge detection. Leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- Tx buffer: one entry. TxReady = !TxFull. Accepting a word sets TxFull. A load clears TxFull. Accept and load in the same cycle: the load takes the old content, the new word is stored, and TxFull stays 1.
- FSM IDLE: MisoOe=0, Miso=0. Synchronized CsN falling -> ACTIVE with BitCnt=0.
  - CPHA=0: load TxShift immediately.
  - CPHA=1: set LoadPend.
- Load: TxShift <= buffer if TxFull. Otherwise TxShift <= 0 and TxUnderrun pulses.
- ACTIVE: MisoOe=1, Miso = TxShift[WordLen-1].
  - Shift edge: if LoadPend, load and clear LoadPend; else shift TxShift left, filling with 0.
  - Sample edge: RxShift <= {RxShift[WordLen-2:0], Mosi_sync}.
    - If BitCnt == WordLen-1: BitCnt <= 0, LoadPend <= 1, and in the next clk RxData <= assembled word with RxValid=1.
    - Otherwise BitCnt++.
  - The BitCnt compare wraps exactly at WordLen-1, with no overshoot. Consecutive words need no CsN deassert.
- Synchronized CsN rising in ACTIVE -> IDLE. MisoOe drops the same cycle. BitCnt, RxShift, and LoadPend are cleared, and TxShift content is discarded; the buffer is retained.
  - If BitCnt != 0: FrameErr pulses and RxValid is not asserted.
  - A CsN rise coinciding with completion of the last sample edge: the word completes first (RxValid pulses) and FrameErr stays 0.
- Edges seen while CsN is high are ignored.
- Latency: RxValid pulses 1 clk after the clk in which the final synchronized sample edge is detected, i.e. about 4 clk after the pin edge.

Decomposition:
- Package spi_pkg: CPOL/CPHA mode constants, FSM state encoding (IDLE, ACTIVE), and a helper for BitCnt width = clog2(WordLen).
- Sub-module spi_slave_sync: 2-FF synchronizers for the three pins plus SCLK rise/fall pulse generation, reused by other SPI-facing blocks.

Test Plan:
1. Mode 0, WordLen=8: TxData=0xA5 preloaded; master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RxData=0x3C; RxValid one clk; TxReady back to 1 after CsN fall.
2. Mode 3: master sends 0x81 then 0x7E in one CsN frame; buffer given 0x55, then 0xAA during word 1 -> RxValid twice (0x81, 0x7E); MISO returns 0x55, 0xAA; no TxUnderrun.
3. Underrun, mode 1: no TxValid before CsN fall -> TxUnderrun single pulse at first shift edge; MISO all 0; RxData still captured correctly.
4. Abort, mode 0: CsN rises after 5 bits -> FrameErr pulse; no RxValid; MisoOe=0 the same clk as synchronized CsN rise; next frame 0xF0 received correctly.
5. Async rst asserted mid-word -> all outputs at reset values immediately, without a clk edge; after release, a mode 2 transfer of 0x12 completes normally.
6. Buffer handshake: TxValid held with 0x11 while TxFull, load and accept in the same clk -> 0x11 captured; TxReady stays 0; no word lost.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: SPI mode constants, responder FSM encoding and bit-counter sizing.
package spi_pkg;
  localparam logic CPOL_LOW   = 1'b0;
  localparam logic CPOL_HIGH  = 1'b1;
  localparam logic CPHA_LEAD  = 1'b0;
  localparam logic CPHA_TRAIL = 1'b1;
  typedef enum logic {IDLE, ACTIVE} state_e;
  function automatic int cnt_w(input int word_len);
    return (word_len < 2) ? 1 : $clog2(word_len);
  endfunction
endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: 2-FF synchronizers for SCLK/CS_n/MOSI plus SCLK rise/fall pulses.
module spi_slave_sync #(
  parameter logic SclkIdle = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_i,
  input  logic csn_i,
  input  logic mosi_i,
  output logic csn_o,
  output logic mosi_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] sclk_q;
  logic [1:0] csn_q;
  logic [1:0] mosi_q;
  // Reset to the idle pin levels so leaving reset never fakes a select or an edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk_q <= {3{SclkIdle}};
      csn_q  <= 2'b11;
      mosi_q <= 2'b00;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk_i};
      csn_q  <= {csn_q[0], csn_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  assign csn_o  = csn_q[1];
  assign mosi_o = mosi_q[1];
  assign rise_o = sclk_q[1] & ~sclk_q[2];
  assign fall_o = ~sclk_q[1] & sclk_q[2];
endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: oversampled SPI responder with word assembly and a one-entry transmit buffer.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int   WordLen = 8,
  parameter logic CPOL    = CPOL_LOW,
  parameter logic CPHA    = CPHA_LEAD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Sclk,
  input  logic               CsN,
  input  logic               Mosi,
  output logic               Miso,
  output logic               MisoOe,
  input  logic [WordLen-1:0] TxData,
  input  logic               TxValid,
  output logic               TxReady,
  output logic [WordLen-1:0] RxData,
  output logic               RxValid,
  output logic               TxUnderrun,
  output logic               FrameErr,
  output logic               Busy
);
  localparam int CW = cnt_w(WordLen);
  localparam logic [CW-1:0] LAST = CW'(WordLen - 1);
  logic csn_s, mosi_s, rise, fall, samp, shft, ld, acc, fin;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WordLen-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d, buf_q, buf_d, rx_q, rx_d;
  logic pend_q, pend_d, full_q, full_d, rxv_q, rxv_d, und_q, und_d, ferr_q, ferr_d;
  spi_slave_sync #(.SclkIdle(CPOL)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .sclk_i (Sclk),
    .csn_i  (CsN),
    .mosi_i (Mosi),
    .csn_o  (csn_s),
    .mosi_o (mosi_s),
    .rise_o (rise),
    .fall_o (fall)
  );
  assign samp = (CPOL ^ CPHA) ? fall : rise;
  assign shft = (CPOL ^ CPHA) ? rise : fall;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_sh_d = rx_sh_q;
    tx_sh_d = tx_sh_q;
    pend_d  = pend_q;
    rx_d    = rx_q;
    rxv_d   = 1'b0;
    ferr_d  = 1'b0;
    ld      = 1'b0;
    fin     = 1'b0;
    if (state_q == IDLE) begin
      if (!csn_s) begin
        state_d = ACTIVE;
        cnt_d   = '0;
        pend_d  = CPHA;
        ld      = !CPHA;
      end
    end else begin
      fin = samp && (cnt_q == LAST);
      if (samp) begin
        rx_sh_d = {rx_sh_q[WordLen-2:0], mosi_s};
        cnt_d   = fin ? '0 : cnt_q + 1'b1;
        pend_d  = pend_q | fin;
        rxv_d   = fin;
        rx_d    = fin ? rx_sh_d : rx_q;
      end
      if (shft) begin
        ld     = pend_q;
        pend_d = 1'b0;
        if (!pend_q) tx_sh_d = tx_sh_q << 1;
      end
      // A word finishing in the deselect cycle still completes and is not an error.
      if (csn_s) begin
        state_d = IDLE;
        cnt_d   = '0;
        rx_sh_d = '0;
        tx_sh_d = '0;
        pend_d  = 1'b0;
        ld      = 1'b0;
        ferr_d  = (cnt_q != '0) && !fin;
      end
    end
    if (ld) tx_sh_d = full_q ? buf_q : '0;
    und_d  = ld & !full_q;
    acc    = TxValid & (!full_q | ld);
    full_d = acc | (full_q & !ld);
    buf_d  = acc ? TxData : buf_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      buf_q   <= '0;
      rx_q    <= '0;
      pend_q  <= 1'b0;
      full_q  <= 1'b0;
      rxv_q   <= 1'b0;
      und_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
      buf_q   <= buf_d;
      rx_q    <= rx_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      rxv_q   <= rxv_d;
      und_q   <= und_d;
      ferr_q  <= ferr_d;
    end
  assign Busy       = state_q == ACTIVE;
  assign MisoOe     = Busy & !csn_s;
  assign Miso       = MisoOe & tx_sh_q[WordLen-1];
  assign TxReady    = !full_q;
  assign RxData     = rx_q;
  assign RxValid    = rxv_q;
  assign TxUnderrun = und_q;
  assign FrameErr   = ferr_q;
endmodule
